// File: rtl/pattern_round_ctrl.sv
// pattern_round_ctrl: runs one memory round per go request. It captures the
// generator pattern, shows it on the LEDs for SHOW_CYCLES, then gives the
// player INPUT_CYCLES to reproduce it and press submit. Each round ends with a
// hit/miss pulse and a saturating score update.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a go rising edge
// CAPTURE | one cycle to let the generator output settle, then latch it
// SHOW    | pattern on ledr, show timer counting down
// WAIT_IN | ledr blank, input timer counting down, waiting for submit
// JUDGE   | one cycle to compare the entry and issue the verdict
module pattern_round_ctrl #(
  parameter int SHOW_CYCLES  = 50000000,
  parameter int INPUT_CYCLES = 250000000,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               go,
  input  logic [17:0]        pattern_in,
  input  logic [17:0]        player_sw,
  input  logic               submit,
  output logic [17:0]        ledr,
  output logic               busy,
  output logic               hit,
  output logic               miss,
  output logic               round_done,
  output logic [SCORE_W-1:0] score
);

  // One down-counter serves both SHOW and WAIT_IN, so size it for the longer.
  localparam int MAXC = (SHOW_CYCLES > INPUT_CYCLES) ? SHOW_CYCLES : INPUT_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SHOW    = 3'd2,
    WAIT_IN = 3'd3,
    JUDGE   = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic               go_d, submit_d;
  logic [TW-1:0]      timer, timer_nxt;
  logic [17:0]        pat, pat_nxt;
  logic [17:0]        entry, entry_nxt;
  logic [17:0]        ledr_nxt;
  logic               hit_nxt, miss_nxt, done_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic               go_rise, sub_rise;

  assign go_rise  = go & ~go_d;
  assign sub_rise = submit & ~submit_d;
  assign busy     = (state != IDLE);

  // State register plus all registered datapath and output pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      go_d       <= 1'b0;
      submit_d   <= 1'b0;
      timer      <= '0;
      pat        <= '0;
      entry      <= '0;
      ledr       <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      round_done <= 1'b0;
      score      <= '0;
    end else begin
      state      <= state_nxt;
      go_d       <= go;
      submit_d   <= submit;
      timer      <= timer_nxt;
      pat        <= pat_nxt;
      entry      <= entry_nxt;
      ledr       <= ledr_nxt;
      hit        <= hit_nxt;
      miss       <= miss_nxt;
      round_done <= done_nxt;
      score      <= score_nxt;
    end
  end

  // Next-state and next-register values; pulses default low so they last one cycle.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pat_nxt   = pat;
    entry_nxt = entry;
    ledr_nxt  = ledr;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    done_nxt  = 1'b0;
    score_nxt = score;
    unique case (state)
      IDLE: begin
        if (go_rise) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        pat_nxt = pattern_in;
        // An all-zero pattern means the generator is not running; abort quietly.
        if (pattern_in == '0) begin
          state_nxt = IDLE;
        end else begin
          ledr_nxt  = pattern_in;
          timer_nxt = TW'(SHOW_CYCLES - 1);
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (timer == '0) begin
          ledr_nxt  = '0;
          timer_nxt = TW'(INPUT_CYCLES - 1);
          state_nxt = WAIT_IN;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      WAIT_IN: begin
        // A submit on the terminal-count cycle still counts as an entry.
        if (sub_rise) begin
          entry_nxt = player_sw;
          state_nxt = JUDGE;
        end else if (timer == '0) begin
          miss_nxt  = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      JUDGE: begin
        if (entry == pat) begin
          hit_nxt = 1'b1;
          if (!(&score)) score_nxt = score + SCORE_W'(1);
        end else begin
          miss_nxt = 1'b1;
        end
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pattern_round_ctrl.sv
// Directed bench for pattern_round_ctrl with SHOW_CYCLES=4, INPUT_CYCLES=10.
// A table of full rounds is replayed through run_round, followed by hand
// sequences for aborted capture, go during SHOW, reset mid-round and score
// saturation.
module tb_pattern_round_ctrl;

  localparam logic [17:0] P1 = 18'b010101101000100000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go;
  logic [17:0] pattern_in;
  logic [17:0] player_sw;
  logic        submit;
  logic [17:0] ledr;
  logic        busy, hit, miss, round_done;
  logic [7:0]  score;

  int n_cmp = 0;
  int n_err = 0;

  pattern_round_ctrl #(
    .SHOW_CYCLES (4),
    .INPUT_CYCLES(10),
    .SCORE_W     (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go),
    .pattern_in(pattern_in),
    .player_sw (player_sw),
    .submit    (submit),
    .ledr      (ledr),
    .busy      (busy),
    .hit       (hit),
    .miss      (miss),
    .round_done(round_done),
    .score     (score)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] pat;
    logic [17:0] sw;
    int          sub_wait;   // WAIT_IN edges before submit rises; -1 = never
    bit          pre_sub;    // raise submit during SHOW and hold it
    bit          exp_hit;
    logic [7:0]  exp_score;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full round starting from IDLE with go and submit low for at least a cycle.
  task automatic run_round(input logic [17:0] p, input logic [17:0] sw, input int sub_wait,
                           input bit pre_sub, input bit exp_hit, input logic [7:0] exp_score);
    go = 1'b1; pattern_in = p; player_sw = sw;
    tick();                                   // go rise sampled -> CAPTURE
    check("capture_busy", busy, 1);
    check("capture_ledr", ledr, 0);
    tick();                                   // CAPTURE -> SHOW, ledr loaded
    go = 1'b0; pattern_in = '0;
    if (pre_sub) submit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("show_ledr", ledr, p);
      tick();
    end
    check("show_end_ledr", ledr, 0);
    check("show_end_busy", busy, 1);
    if (sub_wait < 0) begin
      for (int i = 0; i < 9; i++) begin
        check("wait_quiet", {hit, miss, round_done}, 0);
        tick();
      end
      tick();                                 // 10th WAIT_IN edge: timeout
    end else begin
      repeat (sub_wait) tick();
      submit = 1'b1;
      tick();                                 // sub rise -> JUDGE
      check("judge_quiet", {hit, miss, round_done}, 0);
      check("judge_busy", busy, 1);
      tick();                                 // verdict
    end
    check("hit", hit, exp_hit);
    check("miss", miss, !exp_hit);
    check("round_done", round_done, 1);
    check("score", score, exp_score);
    check("end_idle", busy, 0);
    submit = 1'b0;
    tick();
    check("pulse_clear", {hit, miss, round_done}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{P1,        P1,           0,  1'b0, 1'b1, 8'd1};
    vecs[1] = '{P1,        P1 ^ 18'd1,   3,  1'b0, 1'b0, 8'd1};
    vecs[2] = '{18'h2A5C3, 18'h00000,   -1,  1'b0, 1'b0, 8'd1};
    vecs[3] = '{18'h2A5C3, 18'h2A5C3,    9,  1'b0, 1'b1, 8'd2};
    vecs[4] = '{18'h3FFFF, 18'h3FFFF,    5,  1'b0, 1'b1, 8'd3};
    vecs[5] = '{18'h00001, 18'h20000,    9,  1'b0, 1'b0, 8'd3};
    vecs[6] = '{18'h12345, 18'h12345,   -1,  1'b1, 1'b0, 8'd3};
    vecs[7] = '{18'h00800, 18'h00800,    2,  1'b0, 1'b1, 8'd4};

    reset_n = 1'b0; go = 1'b0; pattern_in = '0; player_sw = '0; submit = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_ledr", ledr, 0);
    check("rst_pulses", {hit, miss, round_done}, 0);
    check("rst_score", score, 0);

    for (int v = 0; v < 8; v++)
      run_round(vecs[v].pat, vecs[v].sw, vecs[v].sub_wait, vecs[v].pre_sub,
                vecs[v].exp_hit, vecs[v].exp_score);

    // Zero pattern: CAPTURE aborts back to IDLE with nothing emitted.
    go = 1'b1; pattern_in = '0;
    tick();
    check("zero_capture_busy", busy, 1);
    tick();
    check("zero_idle", busy, 0);
    check("zero_ledr", ledr, 0);
    check("zero_pulses", {hit, miss, round_done}, 0);
    go = 1'b0;
    tick();
    check("zero_pulses2", {hit, miss, round_done}, 0);
    check("zero_score", score, 4);

    // A second go rise during SHOW must not restart or stretch the round.
    go = 1'b1; pattern_in = P1;
    tick(); tick();
    go = 1'b0; pattern_in = '0;
    tick();
    go = 1'b1; pattern_in = 18'h00003;
    tick();
    check("regow_ledr_a", ledr, P1);
    tick();
    check("regow_ledr_b", ledr, P1);
    tick();
    check("regow_show_end", ledr, 0);
    check("regow_busy", busy, 1);
    go = 1'b0; player_sw = 18'h00003; submit = 1'b1;
    tick(); tick();
    check("regow_miss", miss, 1);
    check("regow_hit", hit, 0);
    check("regow_score", score, 4);
    submit = 1'b0;
    tick();
    check("regow_idle", busy, 0);

    // Reset in the middle of SHOW clears everything immediately.
    go = 1'b1; pattern_in = P1;
    tick(); tick();
    go = 1'b0; pattern_in = '0;
    tick();
    check("mid_show_ledr", ledr, P1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_ledr", ledr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_score", score, 0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    check("rst_after_busy", busy, 0);
    check("rst_after_pulses", {hit, miss, round_done}, 0);

    // Drive the score to all-ones, then one more hit must leave it there.
    for (int i = 1; i <= 255; i++)
      run_round(18'h0F0F0, 18'h0F0F0, 0, 1'b0, 1'b1, 8'(i));
    run_round(18'h0F0F0, 18'h0F0F0, 1, 1'b0, 1'b1, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_round_ctrl.md
Name: pattern_round_ctrl

Overview:
- Downstream consumer of the 18-bit random pattern generator; runs one memory round per request.
- Round sequence: capture the generated pattern, show it on the 18 red LEDs for a fixed time, blank the LEDs, then wait for the player to reproduce it on the 18 switches and press submit.
- Judges the entry, pulses hit/miss and keeps a saturating score.
- Sits between the pattern generator and the LED/HEX display logic in the game top level.

Parameters:
- SHOW_CYCLES, 50000000, number of clk cycles the pattern stays on the LEDs (1 s at 50 MHz); must be at least 1.
- INPUT_CYCLES, 250000000, clk cycles allowed for the player to submit before a timeout miss; must be at least 1.
- SCORE_W, 8, width of the score counter.

Ports:
- clk, input, 1, system clock; all state on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- go, input, 1, round request level; the same signal that drives the generator's start. Synchronous to clk.
- pattern_in, input, 18, generator output; valid while go is high.
- player_sw, input, 18, switch entry from the player.
- submit, input, 1, debounced active-high submit level; only its rising edge is used.
- ledr, output, 18, LED drive; shows the pattern during SHOW, otherwise 0.
- busy, output, 1, high in any state other than IDLE.
- hit, output, 1, one-cycle pulse when the entry matches.
- miss, output, 1, one-cycle pulse on a mismatch or a timeout.
- round_done, output, 1, one-cycle pulse coincident with hit or miss.
- score, output, SCORE_W, number of hits; saturates at all-ones.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE.
  - ledr, hit, miss, round_done, score, timer, captured pattern = 0.
  - go_d and submit_d edge registers = 0.
  - Reset asserted mid-round aborts the round immediately with no pulses. After release, the block sits in IDLE.
- Edge detection:
  - go_d and submit_d are registered copies of go and submit.
  - go rise = go & ~go_d. sub rise = submit & ~submit_d.
- States: IDLE, CAPTURE, SHOW, WAIT_IN, JUDGE.
- IDLE:
  - On go rise, move to CAPTURE.
  - go edges in any other state are ignored. No queueing.
- CAPTURE (1 cycle; gives the generator's start-edge-updated output time to settle):
  - pat <= pattern_in.
  - If pattern_in == 0 (generator in reset or go already dropped): return to IDLE with no pulses and no score change.
  - Otherwise: ledr <= pattern_in, timer <= SHOW_CYCLES-1, move to SHOW.
- SHOW:
  - ledr holds pat for exactly SHOW_CYCLES cycles.
  - timer decrements each cycle.
  - On the edge where timer == 0: ledr <= 0, timer <= INPUT_CYCLES-1, move to WAIT_IN.
  - submit edges during SHOW are ignored. submit_d still tracks submit, so a submit held high across the transition does not count as a rise.
- WAIT_IN:
  - On sub rise: latch player_sw into entry, move to JUDGE.
  - Else if timer == 0: miss = 1, round_done = 1, move to IDLE.
  - Else: decrement timer.
  - If sub rise and timer == 0 happen in the same cycle, submit wins.
- JUDGE (1 cycle):
  - If entry == pat: hit = 1, and score increments unless it is already all-ones.
  - Else: miss = 1.
  - round_done = 1 in both cases. Next state IDLE.
- Output timing:
  - hit, miss and round_done are registered and high for exactly one cycle.
  - hit and miss are never high together.
- Latency:
  - The first cycle with ledr == pattern is 2 clk edges after the go rise is sampled.
  - The verdict appears 2 edges after the submit rise is sampled.
- score is never cleared except by reset.
- busy = (state != IDLE), combinational from the state register.

Test Plan:
(Bench uses SHOW_CYCLES=4, INPUT_CYCLES=10.)
- Reset then go rise with pattern_in=18'b010101101000100000 -> ledr equals the pattern for exactly 4 cycles starting 2 edges after the go rise, then ledr=0; busy high from the CAPTURE cycle onward.
- In WAIT_IN, player_sw = pattern, submit rise -> hit and round_done pulse once, 2 edges later; score 0->1; state returns to IDLE.
- player_sw = pattern with bit 0 flipped, submit -> miss and round_done pulse; score unchanged.
- No submit for 10 cycles of WAIT_IN -> miss and round_done on the 10th edge; submit rise on that same edge -> judged instead, hit if matching.
- go rise with pattern_in=0 -> back to IDLE after CAPTURE, no pulses, ledr stays 0. Second go rise during SHOW -> ignored. reset_n low during SHOW -> ledr=0 and busy=0 immediately, score=0.
- Force score to 255 via repeated hits (SCORE_W=8) -> further hits pulse hit but score stays 255.
